// File: rtl/game_pkg.sv
// game_pkg: board geometry, FSM encodings and LFSR/gap helpers for the drone-dodge game
package game_pkg;
  localparam int BOARD_H = 20;
  localparam int BOARD_W = 40;
  localparam int GAP_W = 4;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DEAD = 2'd2;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // A single fold suffices because BOARD_W-GAP_W is at least 32 and r is 6 bits
  function automatic logic [BOARD_W-1:0] gap_bf(input logic [5:0] r);
    int g;
    g = (int'(r) >= BOARD_W - GAP_W) ? int'(r) - (BOARD_W - GAP_W) : int'(r);
    return ~(BOARD_W'((1 << GAP_W) - 1) << g);
  endfunction
endpackage

// File: rtl/wave_gen.sv
// wave_gen: free-running LFSR and per-wave gap decoders producing the next drone bitfields
module wave_gen
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  output logic [BOARD_W-1:0] bf0,
  output logic [BOARD_W-1:0] bf1,
  output logic [BOARD_W-1:0] bf2
);
  logic [15:0] lfsr_q, lfsr_d;
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
    bf0 = gap_bf(lfsr_q[5:0]);
    bf1 = gap_bf(lfsr_q[11:6]);
    bf2 = gap_bf({lfsr_q[15:12], lfsr_q[1:0]});
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else lfsr_q <= lfsr_d;
endmodule

// File: rtl/wave_scheduler.sv
// wave_scheduler: drone-dodge game flow - wave stepping, collision, score, speed ramp, frame req/ack
module wave_scheduler
  import game_pkg::*;
#(
  parameter int TICK_DIV = 5_000_000,
  parameter int MIN_DIV = 500_000,
  parameter int DIV_DEC = 250_000,
  parameter int SPEED_STEP = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         player_x,
  input  logic [7:0]         player_y,
  output logic [7:0]         wave0_y,
  output logic [7:0]         wave1_y,
  output logic [7:0]         wave2_y,
  output logic [BOARD_W-1:0] wave0_bf,
  output logic [BOARD_W-1:0] wave1_bf,
  output logic [BOARD_W-1:0] wave2_bf,
  output logic [15:0]        score,
  output logic [15:0]        high_score,
  output logic               dead,
  output logic               frame_req,
  input  logic               frame_ack
);
  localparam int SH = $clog2(SPEED_STEP);
  logic [1:0] state_q, state_d;
  logic [7:0] y_q[3], y_d[3];
  logic [BOARD_W-1:0] bf_q[3], bf_d[3], nbf[3], sh;
  logic [15:0] score_q, score_d, high_q, high_d, sat;
  logic [31:0] div_q, div_d, cnt_q, cnt_d;
  logic dead_q, dead_d, req_q, req_d, tick, hit, ev;
  logic [1:0] inc;
  logic [16:0] sum;

  wave_gen u_gen (.clk(clk), .rst_n(rst_n), .bf0(nbf[0]), .bf1(nbf[1]), .bf2(nbf[2]));

  always_comb begin
    hit = 1'b0;
    sh = '0;
    // shifting by player_x drops out-of-range columns to zero
    for (int k = 0; k < 3; k++) begin
      sh = bf_q[k] >> player_x;
      hit = hit | (y_q[k] == player_y && sh[0]);
    end
    tick = state_q == RUN && cnt_q == div_q - 32'd1;
    state_d = state_q;
    y_d = y_q;
    bf_d = bf_q;
    score_d = score_q;
    high_d = high_q;
    div_d = div_q;
    cnt_d = cnt_q;
    dead_d = dead_q;
    inc = 2'd0;
    sum = '0;
    sat = '0;
    ev = 1'b0;
    if (start && state_q != RUN) begin
      state_d = RUN;
      score_d = '0;
      cnt_d = '0;
      dead_d = 1'b0;
      ev = 1'b1;
      for (int k = 0; k < 3; k++) begin
        y_d[k] = 8'(BOARD_H - 2 - 6 * k);
        bf_d[k] = nbf[k];
      end
    end else if (state_q == RUN && hit) begin
      state_d = DEAD;
      dead_d = 1'b1;
      high_d = score_q > high_q ? score_q : high_q;
      ev = 1'b1;
    end else if (state_q == RUN) begin
      cnt_d = tick ? '0 : cnt_q + 32'd1;
      if (tick) begin
        for (int k = 0; k < 3; k++) begin
          if (y_q[k] == 8'd1) begin
            y_d[k] = 8'(BOARD_H - 2);
            bf_d[k] = nbf[k];
            inc = inc + 2'd1;
          end else if (y_q[k] > 8'd1) y_d[k] = y_q[k] - 8'd1;
        end
        sum = {1'b0, score_q} + 17'(inc);
        sat = sum[16] ? 16'hFFFF : sum[15:0];
        score_d = sat;
        if ((sat >> SH) != (score_q >> SH))
          div_d = (div_q < 32'(MIN_DIV + DIV_DEC)) ? 32'(MIN_DIV) : div_q - 32'(DIV_DEC);
        ev = 1'b1;
      end
    end
    req_d = ev | (req_q & ~frame_ack);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      for (int k = 0; k < 3; k++) begin
        y_q[k] <= 8'(BOARD_H - 2 - 6 * k);
        bf_q[k] <= '0;
      end
      score_q <= '0;
      high_q <= '0;
      div_q <= 32'(TICK_DIV);
      cnt_q <= '0;
      dead_q <= 1'b0;
      req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q <= y_d;
      bf_q <= bf_d;
      score_q <= score_d;
      high_q <= high_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      dead_q <= dead_d;
      req_q <= req_d;
    end

  assign wave0_y = y_q[0];
  assign wave1_y = y_q[1];
  assign wave2_y = y_q[2];
  assign wave0_bf = bf_q[0];
  assign wave1_bf = bf_q[1];
  assign wave2_bf = bf_q[2];
  assign score = score_q;
  assign high_score = high_q;
  assign dead = dead_q;
  assign frame_req = req_q;
endmodule

// File: tb/tb_wave_scheduler.sv
// tb_wave_scheduler: directed checks of wave stepping, collision, scoring, speed-up and frame handshake
module tb_wave_scheduler;
  logic clk = 0, rst_n = 0, start = 0, frame_ack = 0;
  logic [7:0] px = 0, py = 25;
  logic [7:0] wave0_y, wave1_y, wave2_y;
  logic [39:0] wave0_bf, wave1_bf, wave2_bf;
  logic [15:0] score, high_score;
  logic dead, frame_req;
  logic [15:0] m, mp;
  logic [39:0] e0, e1, e2;
  logic [7:0] l1, l2;
  int checks = 0, failures = 0, w, n;
  bit got;

  wave_scheduler #(.TICK_DIV(4), .MIN_DIV(2), .DIV_DEC(1), .SPEED_STEP(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .player_x(px), .player_y(py),
    .wave0_y(wave0_y), .wave1_y(wave1_y), .wave2_y(wave2_y),
    .wave0_bf(wave0_bf), .wave1_bf(wave1_bf), .wave2_bf(wave2_bf),
    .score(score), .high_score(high_score), .dead(dead),
    .frame_req(frame_req), .frame_ack(frame_ack)
  );

  always #5 clk = ~clk;

  // reference LFSR; mp holds the value seen during the previous cycle
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m <= 16'hACE1;
      mp <= 16'hACE1;
    end else begin
      mp <= m;
      m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end

  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  function automatic logic [39:0] exp_bf(input logic [5:0] r);
    int g;
    logic [39:0] b;
    g = (r >= 6'd36) ? int'(r) - 36 : int'(r);
    for (int i = 0; i < 40; i++) b[i] = !(i >= g && i < g + 4);
    return b;
  endfunction

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_y"}, {wave0_y, wave1_y, wave2_y}, {8'd18, 8'd12, 8'd6});
    chk({tag, "_bf"}, wave0_bf | wave1_bf | wave2_bf, 0);
    chk({tag, "_misc"}, {score, high_score, frame_req, dead}, 0);
  endtask

  initial begin
    cyc(2);
    rst_n = 1;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (i % 25 == 24) rst_chk("idle");
    end
    start = 1;
    cyc(1);
    start = 0;
    chk("hs_req_set", frame_req, 1);
    cyc(1);
    chk("hs_req_hold", frame_req, 1);
    cyc(1);
    frame_ack = 1;
    cyc(1);
    chk("hs_req_clear", frame_req, 0);
    cyc(1);
    chk("hs_ev_ack", frame_req, 1);
    chk("tick1_y0", wave0_y, 17);
    frame_ack = 0;
    rst_n = 0;
    #1;
    rst_chk("rst_run");
    cyc(1);
    rst_n = 1;
    py = 17;
    px = 39;
    e0 = exp_bf(m[5:0]);
    e1 = exp_bf(m[11:6]);
    e2 = exp_bf({m[15:12], m[1:0]});
    start = 1;
    cyc(1);
    start = 0;
    chk("start_bf0", wave0_bf, e0);
    chk("start_bf1", wave1_bf, e1);
    chk("start_bf2", wave2_bf, e2);
    cyc(4);
    chk("r17_y0", wave0_y, 17);
    chk("r17_alive", dead, 0);
    cyc(1);
    chk("r17_dead", dead, 1);
    chk("r17_frozen", wave0_y, 17);
    chk("r17_high", high_score, 0);
    py = 18;
    px = 40;
    start = 1;
    cyc(1);
    start = 0;
    chk("restart_dead_clr", dead, 0);
    cyc(3);
    chk("x40_nohit", dead, 0);
    px = 39;
    cyc(1);
    chk("tickhit_dead", dead, 1);
    chk("tickhit_y", {wave0_y, wave1_y, wave2_y}, {8'd18, 8'd12, 8'd6});
    py = 25;
    px = 0;
    w = 0;
    while (m[5:0] != 6'd63 && w < 70000) begin
      cyc(1);
      w++;
    end
    chk("r63_found", w < 70000, 1);
    start = 1;
    cyc(1);
    start = 0;
    chk("r63_bf0", wave0_bf, 40'hFF87FFFFFF);
    l1 = wave1_y;
    l2 = wave2_y;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      cyc(1);
      if (l2 == 8'd1 && wave2_y == 8'd18) begin
        chk("bf2_respawn", wave2_bf, exp_bf({mp[15:12], mp[1:0]}));
        chk("score1", score, 1);
      end
      if (l1 == 8'd1 && wave1_y == 8'd18) begin
        chk("bf1_respawn", wave1_bf, exp_bf(mp[11:6]));
        chk("score2", score, 2);
        chk("y0_t12", wave0_y, 6);
        chk("y2_t12", wave2_y, 12);
        got = 1;
      end
      l1 = wave1_y;
      l2 = wave2_y;
    end
    chk("respawn_seen", got, 1);
    n = 0;
    while (wave0_y == 8'd6 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("div3_interval", n, 3);
    py = 5;
    px = 39;
    w = 0;
    while (!dead && w < 20) begin
      cyc(1);
      w++;
    end
    chk("hs_dead", dead, 1);
    chk("hs_high2", high_score, 2);
    chk("hs_score2", score, 2);
    py = 25;
    start = 1;
    cyc(1);
    start = 0;
    chk("restart_score0", score, 0);
    chk("hs_kept", high_score, 2);
    cyc(2);
    rst_n = 0;
    #1;
    rst_chk("rst_lost");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
